mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter EXT_OPS, default 1: 1 = BNE, ANDI, ORI, SLTI are legal opcodes; 0 = those opcodes are illegal.
REQ-002 clk  in  1  single clock, all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  opcode from the instruction register, stable from DECODE until the next FETCH.
REQ-005 funct  in  6  function field from the instruction register.
REQ-006 zero  in  1  ALU zero flag, valid in the branch state.
REQ-007 iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, zeroext  out  1 each  datapath strobes and muxes.
REQ-008 alusrcb  out  2  00 reg B, 01 constant 4, 10 immediate, 11 immediate<<2.
REQ-009 pcsrc  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-010 pcen  out  1  PC register enable.
REQ-011 alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 state  out  4  current FSM state code (REQ-014), for debug.
REQ-013 illegal  out  1  sticky illegal-instruction flag.

Function
REQ-014 State register SHALL use codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BEQ=8, IMMEX=9, IMMWB=10, JUMP=11, BNE=12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-015 Transitions SHALL be FETCH->DECODE; DECODE->MEMADR (op 100011/101011), RTYPEEX (000000), BEQ (000100), IMMEX (001000, plus 001100/001101/001010 when EXT_OPS=1), JUMP (000010), BNE (000101 when EXT_OPS=1), else FETCH.
REQ-016 MEMADR->MEMRD for lw, MEMWR for sw; MEMRD->MEMWB; RTYPEEX->ALUWB; IMMEX->IMMWB; MEMWB, MEMWR, ALUWB, IMMWB, BEQ, BNE, JUMP->FETCH.
REQ-017 Resulting instruction latencies SHALL be lw 5, sw 4, R-type 4, addi/andi/ori/slti 4, beq/bne 3, j 3, illegal 2 cycles.
REQ-018 Moore outputs SHALL be 0 except: FETCH irwrite=1, pcwrite=1, alusrcb=01, aluop=00; DECODE alusrcb=11, aluop=00; MEMADR alusrca=1, alusrcb=10; MEMRD iord=1; MEMWB memtoreg=1, regwrite=1; MEMWR iord=1, memwrite=1.
REQ-019 Further: RTYPEEX alusrca=1, alusrcb=00, aluop=10; ALUWB regdst=1, regwrite=1; BEQ/BNE alusrca=1, alusrcb=00, aluop=01, pcsrc=01; IMMEX alusrca=1, alusrcb=10, aluop=11; IMMWB regwrite=1; JUMP pcsrc=10, pcwrite=1.
REQ-020 pcen SHALL equal pcwrite OR (state==BEQ AND zero) OR (state==BNE AND NOT zero), combinationally.
REQ-021 alucontrol SHALL be 010 for aluop 00, 110 for aluop 01, by funct for aluop 10 (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other 010).
REQ-022 For aluop 11 alucontrol SHALL be 010 for addi, 000 andi, 001 ori, 111 slti.
REQ-023 zeroext SHALL be 1 only in IMMEX and IMMWB with op andi or ori.
REQ-024 No output SHALL ever be X; unsupported cases resolve to the stated defaults.
REQ-025 illegal SHALL set on the edge leaving DECODE with an unsupported op, or leaving RTYPEEX with an unsupported funct, and hold until reset; execution continues.
REQ-026 An unsupported R-type funct SHALL still complete ALUWB (regwrite asserted) with alucontrol 010.

Reset
REQ-027 reset high at an edge SHALL force state=FETCH and illegal=0 regardless of current state, including mid-instruction.
REQ-028 Outputs during and after reset SHALL be FETCH outputs: irwrite=1, pcen=1, alusrcb=01, alucontrol=010, all else 0.
REQ-029 reset SHALL take priority over every transition and illegal-flag set on the same edge.

Verification
REQ-030 Reset then op=100011: state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-031 op=000000, funct=101010: states 0,1,6,7,0; alucontrol=111 in state 6; regdst=1, regwrite=1 in state 7.
REQ-032 op=000100 with zero=1 then zero=0: pcen=1 in state 8 then pcen=0; with EXT_OPS=1, op=000101, zero=0 gives pcen=1 in state 12.
REQ-033 EXT_OPS=1, op=001101: states 0,1,9,10,0; alucontrol=001, zeroext=1; with EXT_OPS=0 same op: states 0,1,0 and illegal=1 afterwards.
REQ-034 op=000000, funct=111111: illegal rises after state 6, stays 1 across later legal instructions until reset.
REQ-035 reset asserted in MEMRD: next state 0, illegal=0, memwrite/regwrite never asserted for the aborted lw.

Source files
------------

// File: rtl/mc_controller_if.sv
// Signal bundle between the multicycle datapath and its control FSM.
// The datapath side drives the instruction fields and the zero flag; the controller drives everything else.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       zeroext;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       illegal;

    modport master (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, zeroext,
        input  alusrcb, pcsrc, pcen, alucontrol, state, illegal
    );

    modport slave (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, zeroext,
        output alusrcb, pcsrc, pcen, alucontrol, state, illegal
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit: Moore FSM with ALU decoder and sticky illegal-instruction flag.
// EXT_OPS enables BNE, ANDI, ORI and SLTI on top of the base instruction set.
module mc_controller #(
    parameter int EXT_OPS = 1
) (
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.slave bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_BNE     = 4'd12
    } state_t;

    localparam logic EXT = (EXT_OPS != 0);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_illegal;
    logic       w_pcwrite;
    logic [1:0] w_aluop;

    logic w_is_lw, w_is_sw, w_is_rtype, w_is_beq, w_is_bne, w_is_j;
    logic w_is_addi, w_is_andi, w_is_ori, w_is_slti, w_is_imm;
    logic w_op_legal, w_funct_legal;

    // Extended opcodes decode as "not present" when EXT_OPS is 0, which makes them illegal.
    always_comb begin
        w_is_lw    = (bus.op == 6'b100011);
        w_is_sw    = (bus.op == 6'b101011);
        w_is_rtype = (bus.op == 6'b000000);
        w_is_beq   = (bus.op == 6'b000100);
        w_is_j     = (bus.op == 6'b000010);
        w_is_addi  = (bus.op == 6'b001000);
        w_is_bne   = EXT && (bus.op == 6'b000101);
        w_is_andi  = EXT && (bus.op == 6'b001100);
        w_is_ori   = EXT && (bus.op == 6'b001101);
        w_is_slti  = EXT && (bus.op == 6'b001010);
        w_is_imm   = w_is_addi || w_is_andi || w_is_ori || w_is_slti;
        w_op_legal = w_is_lw || w_is_sw || w_is_rtype || w_is_beq || w_is_bne || w_is_j || w_is_imm;
        w_funct_legal = (bus.funct == 6'b100000) || (bus.funct == 6'b100010) ||
                        (bus.funct == 6'b100100) || (bus.funct == 6'b100101) ||
                        (bus.funct == 6'b101010);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_DECODE && !w_op_legal) || (r_state == S_RTYPEEX && !w_funct_legal))
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_state_next = S_DECODE;
            S_DECODE: begin
                if (w_is_lw || w_is_sw) w_state_next = S_MEMADR;
                else if (w_is_rtype)    w_state_next = S_RTYPEEX;
                else if (w_is_beq)      w_state_next = S_BEQ;
                else if (w_is_bne)      w_state_next = S_BNE;
                else if (w_is_imm)      w_state_next = S_IMMEX;
                else if (w_is_j)        w_state_next = S_JUMP;
                else                    w_state_next = S_FETCH;
            end
            S_MEMADR:  w_state_next = w_is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_state_next = S_MEMWB;
            S_RTYPEEX: w_state_next = S_ALUWB;
            S_IMMEX:   w_state_next = S_IMMWB;
            default:   w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        bus.iord     = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        w_pcwrite    = 1'b0;
        w_aluop      = 2'b00;
        case (r_state)
            S_FETCH: begin
                bus.irwrite = 1'b1;
                w_pcwrite   = 1'b1;
                bus.alusrcb = 2'b01;
            end
            S_DECODE:  bus.alusrcb = 2'b11;
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD:   bus.iord = 1'b1;
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                w_aluop     = 2'b10;
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BEQ, S_BNE: begin
                bus.alusrca = 1'b1;
                w_aluop     = 2'b01;
                bus.pcsrc   = 2'b01;
            end
            S_IMMEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                w_aluop     = 2'b11;
            end
            S_IMMWB:   bus.regwrite = 1'b1;
            S_JUMP: begin
                bus.pcsrc = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Unknown funct or immediate opcode falls back to add so the ALU result is always defined.
    always_comb begin
        bus.alucontrol = 3'b010;
        case (w_aluop)
            2'b01: bus.alucontrol = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100010: bus.alucontrol = 3'b110;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default:   bus.alucontrol = 3'b010;
                endcase
            end
            2'b11: begin
                if (w_is_andi)      bus.alucontrol = 3'b000;
                else if (w_is_ori)  bus.alucontrol = 3'b001;
                else if (w_is_slti) bus.alucontrol = 3'b111;
                else                bus.alucontrol = 3'b010;
            end
            default: bus.alucontrol = 3'b010;
        endcase
    end

    assign bus.zeroext = ((r_state == S_IMMEX) || (r_state == S_IMMWB)) && (w_is_andi || w_is_ori);
    assign bus.pcen    = w_pcwrite || ((r_state == S_BEQ) && bus.zero) || ((r_state == S_BNE) && !bus.zero);
    assign bus.state   = r_state;
    assign bus.illegal = r_illegal;
endmodule

// File: tb/tb_mc_controller.sv
// Checks an EXT_OPS=1 and an EXT_OPS=0 controller side by side against an instruction-level model
// that knows each opcode's state path and the per-state control word.
module tb_mc_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_controller_if bus1 ();
    mc_controller_if bus0 ();

    mc_controller #(.EXT_OPS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mc_controller #(.EXT_OPS(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    int tests  = 0;
    int errors = 0;
    logic sticky1, sticky0;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         n;
    } vec_t;

    function automatic bit funct_ok(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 || f == 6'b100101 || f == 6'b101010;
    endfunction

    // Ordered list of states one instruction visits, starting at FETCH.
    function automatic void get_path(input logic [5:0] op, input bit ext, output int p[$], output int ill_pos);
        p = {0, 1};
        ill_pos = -1;
        case (op)
            6'b100011: p = {0, 1, 2, 3, 4};
            6'b101011: p = {0, 1, 2, 5};
            6'b000000: p = {0, 1, 6, 7};
            6'b000100: p = {0, 1, 8};
            6'b000010: p = {0, 1, 11};
            6'b001000: p = {0, 1, 9, 10};
            6'b000101: if (ext) p = {0, 1, 12}; else ill_pos = 1;
            6'b001100, 6'b001101, 6'b001010: if (ext) p = {0, 1, 9, 10}; else ill_pos = 1;
            default:   ill_pos = 1;
        endcase
    endfunction

    // Control word {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,zeroext,alusrcb,pcsrc,pcen,alucontrol}.
    function automatic logic [15:0] exp_word(input int st, input logic [5:0] op, input logic [5:0] funct, input logic zero);
        logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, asa = 0, zx = 0, pcw = 0;
        logic [1:0] asb = 0, pcs = 0, aluop = 0;
        logic [2:0] ac;
        case (st)
            0:  begin irw = 1; pcw = 1; asb = 2'b01; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin asa = 1; aluop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8, 12: begin asa = 1; aluop = 2'b01; pcs = 2'b01; end
            9:  begin asa = 1; asb = 2'b10; aluop = 2'b11; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        if ((st == 9 || st == 10) && (op == 6'b001100 || op == 6'b001101)) zx = 1;
        case (aluop)
            2'b01: ac = 3'b110;
            2'b10: case (funct)
                       6'b100010: ac = 3'b110;
                       6'b100100: ac = 3'b000;
                       6'b100101: ac = 3'b001;
                       6'b101010: ac = 3'b111;
                       default:   ac = 3'b010;
                   endcase
            2'b11: case (op)
                       6'b001100: ac = 3'b000;
                       6'b001101: ac = 3'b001;
                       6'b001010: ac = 3'b111;
                       default:   ac = 3'b010;
                   endcase
            default: ac = 3'b010;
        endcase
        return {iord, mw, irw, rd, m2r, rw, asa, zx, asb, pcs,
                pcw | (st == 8 && zero) | (st == 12 && !zero), ac};
    endfunction

    function automatic logic [15:0] act_word(input bit ext);
        if (ext)
            return {bus1.iord, bus1.memwrite, bus1.irwrite, bus1.regdst, bus1.memtoreg, bus1.regwrite,
                    bus1.alusrca, bus1.zeroext, bus1.alusrcb, bus1.pcsrc, bus1.pcen, bus1.alucontrol};
        return {bus0.iord, bus0.memwrite, bus0.irwrite, bus0.regdst, bus0.memtoreg, bus0.regwrite,
                bus0.alusrca, bus0.zeroext, bus0.alusrcb, bus0.pcsrc, bus0.pcen, bus0.alucontrol};
    endfunction

    task automatic check_one(input bit ext, input int k, input logic [5:0] op, input logic [5:0] funct,
                             input logic zero, input logic sticky);
        int p[$];
        int ill_pos;
        int st;
        logic exp_ill;
        logic [3:0]  a_state;
        logic        a_ill;
        logic [15:0] a_word, e_word;
        get_path(op, ext, p, ill_pos);
        if (ill_pos < 0 && op == 6'b000000 && !funct_ok(funct)) ill_pos = 2;
        st = p[k % p.size()];
        exp_ill = sticky | (ill_pos >= 0 && k > ill_pos);
        a_state = ext ? bus1.state : bus0.state;
        a_ill   = ext ? bus1.illegal : bus0.illegal;
        a_word  = act_word(ext);
        e_word  = exp_word(st, op, funct, zero);
        tests += 3;
        if (a_state !== st[3:0]) begin
            errors++;
            $display("FAIL state ext=%0d op=%b funct=%b k=%0d got %0d want %0d", ext, op, funct, k, a_state, st);
        end
        if (a_word !== e_word) begin
            errors++;
            $display("FAIL ctrl ext=%0d op=%b funct=%b z=%b st=%0d got %b want %b", ext, op, funct, zero, st, a_word, e_word);
        end
        if (a_ill !== exp_ill) begin
            errors++;
            $display("FAIL illegal ext=%0d op=%b funct=%b k=%0d got %b want %b", ext, op, funct, k, a_ill, exp_ill);
        end
    endtask

    // One instruction, repeated for n cycles; without reset the previous run must end on a last state.
    task automatic run(input logic [5:0] op, input logic [5:0] funct, input logic zero, input bit do_rst, input int n);
        int p1[$], p0[$];
        int i1, i0;
        logic s1, s0;
        bus1.op = op; bus1.funct = funct; bus1.zero = zero;
        bus0.op = op; bus0.funct = funct; bus0.zero = zero;
        if (do_rst) begin
            reset = 1'b1;
            sticky1 = 1'b0;
            sticky0 = 1'b0;
        end
        @(negedge clk);
        s1 = sticky1;
        s0 = sticky0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            check_one(1'b1, k, op, funct, zero, s1);
            check_one(1'b0, k, op, funct, zero, s0);
            reset = 1'b0;
        end
        get_path(op, 1'b1, p1, i1);
        get_path(op, 1'b0, p0, i0);
        if (i1 < 0 && op == 6'b000000 && !funct_ok(funct)) i1 = 2;
        if (i0 < 0 && op == 6'b000000 && !funct_ok(funct)) i0 = 2;
        sticky1 = s1 | (i1 >= 0 && n - 1 > i1);
        sticky0 = s0 | (i0 >= 0 && n - 1 > i0);
        $display("[TB] op=%b funct=%b zero=%b rst=%0d cycles=%0d errors=%0d", op, funct, zero, do_rst, n, errors);
    endtask

    vec_t vecs[20];
    logic [5:0] op_pool[12];
    logic [5:0] fn_pool[7];

    initial begin
        sticky1 = 1'b0;
        sticky0 = 1'b0;
        vecs = '{
            '{6'b100011, 6'b000000, 1'b0, 6},
            '{6'b101011, 6'b000000, 1'b0, 5},
            '{6'b000000, 6'b101010, 1'b0, 5},
            '{6'b000000, 6'b100000, 1'b1, 4},
            '{6'b000000, 6'b100010, 1'b0, 4},
            '{6'b000000, 6'b100100, 1'b0, 4},
            '{6'b000000, 6'b100101, 1'b0, 4},
            '{6'b000000, 6'b111111, 1'b0, 5},
            '{6'b000100, 6'b000000, 1'b1, 4},
            '{6'b000100, 6'b000000, 1'b0, 4},
            '{6'b000101, 6'b000000, 1'b0, 4},
            '{6'b000101, 6'b000000, 1'b1, 4},
            '{6'b001000, 6'b000000, 1'b0, 5},
            '{6'b001100, 6'b000000, 1'b0, 5},
            '{6'b001101, 6'b000000, 1'b0, 5},
            '{6'b001010, 6'b000000, 1'b0, 5},
            '{6'b000010, 6'b000000, 1'b0, 4},
            '{6'b111111, 6'b000000, 1'b0, 3},
            '{6'b000001, 6'b000000, 1'b1, 3},
            '{6'b100011, 6'b100000, 1'b1, 2}
        };
        foreach (vecs[i]) run(vecs[i].op, vecs[i].funct, vecs[i].zero, 1'b1, vecs[i].n);

        // Sticky illegal flag survives later legal instructions until reset clears it.
        run(6'b000000, 6'b111111, 1'b0, 1'b1, 4);
        run(6'b100011, 6'b000000, 1'b0, 1'b0, 5);
        run(6'b000100, 6'b000000, 1'b1, 1'b0, 3);
        run(6'b000000, 6'b100000, 1'b0, 1'b1, 4);

        // Reset landing in MEMRD aborts the load before any write strobe.
        run(6'b100011, 6'b000000, 1'b0, 1'b1, 4);
        run(6'b100011, 6'b000000, 1'b0, 1'b1, 3);

        // Reset on the edge that would set the flag: ends in DECODE with an illegal op.
        run(6'b111110, 6'b000000, 1'b0, 1'b1, 2);
        run(6'b000010, 6'b000000, 1'b0, 1'b1, 3);

        op_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000,
                    6'b001100, 6'b001101, 6'b001010, 6'b000010, 6'b000000, 6'b000000};
        fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b111111};
        for (int t = 0; t < 150; t++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 11)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 6)];
            run(op, fn, 1'($urandom), 1'b1, $urandom_range(1, 12));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
